case_sequencer: RTL
===================

Name: case_sequencer

Overview:
- Upstream stage for the one-hot LED lighter; generates its 2-bit `Case` select.
- Auto mode steps `Case` through 0..3 at a fixed prescaled rate.
- Manual mode steps `Case` once per debounced push-button press.
- Outputs `Case[1:0]` and a one-cycle `tick` strobe marking each change.

Parameters:
- TICK_DIV, 50000000, clock cycles per auto-advance (1 Hz at 50 MHz); minimum 2
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); minimum 1

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- run  input  1  1 = auto-advance on prescaler, 0 = manual step mode
- dir  input  1  0 = count up, 1 = count down
- step_btn  input  1  raw asynchronous button, active-high
- Case  output  2  current select value to LED lighter
- tick  output  1  one-cycle pulse in the cycle `Case` holds a new value

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is asynchronous and active-high on port `reset`.
- Reset effect: immediate, no clock edge needed.
  - Outputs: `Case`=2'b00, `tick`=0.
  - Internal: prescaler=0, both synchronizer flops=0, debounced level=0, debounce count=0, debounce FSM=IDLE_LOW.
- Synchronizer: `step_btn` passes through 2 flops, giving `sync_btn`.
- Debounce FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: `sync_btn`=1 -> WAIT_HIGH, count=1.
  - WAIT_HIGH: `sync_btn`=0 -> IDLE_LOW, count=0. Count reaches DEBOUNCE_CYCLES -> IDLE_HIGH, debounced level=1.
  - IDLE_HIGH / WAIT_LOW: mirror image of the above, with debounced level=0 on exit to IDLE_LOW.
- step_req: debounced level AND NOT (debounced level delayed one cycle).
- Prescaler:
  - While `run`=1: counts 0..TICK_DIV-1 and wraps. At terminal count it asserts `adv_auto`.
  - While `run`=0: held at 0. After `run` rises, the first advance occurs exactly TICK_DIV cycles later.
- Advance condition: adv = (`run` & `adv_auto`) | (~`run` & step_req). step_req is ignored while `run`=1.
- On adv:
  - `Case` <= `Case`+1 mod 4 if `dir`=0, else `Case`-1 mod 4.
  - `dir` is sampled only in the adv cycle.
  - Wrap 3->0 (up) and 0->3 (down) are seamless.
- tick: registered copy of adv. It is high for exactly the cycle after the edge that updates `Case`. It is never high two consecutive cycles unless TICK_DIV=1, which is disallowed.
- Latency:
  - Auto mode: `Case` first changes on rising edge TICK_DIV after reset release, then every TICK_DIV edges.
  - Button: `Case` updates on edge DEBOUNCE_CYCLES+3 counted from the first edge sampling `step_btn`=1.
- Boundary conditions:
  - Glitches shorter than DEBOUNCE_CYCLES produce no step.
  - A held button produces exactly one step; release and re-press is required for the next.
  - A button held through reset release produces one step after debounce.
  - `run` falling in the terminal-count cycle: no advance (`run` gates adv).
  - `dir` changing mid-interval: no effect until the next adv.
  - Reset mid-operation discards pending debounce and prescaler progress.

Optional Feature:
- Macro: CASE_SEQUENCER_PINGPONG_EN.
- Defined:
  - `dir` port is ignored. An internal direction flag (reset = up) sets the step direction.
  - The flag flips on adv when `Case`=3 going up or `Case`=0 going down, so the sequence runs 0,1,2,3,2,1,0,1,...
  - Applies in both auto and manual modes.
- Undefined: direction comes from `dir` with mod-4 wrap, as above.

Test Plan:
- TICK_DIV=4, reset pulse, `run`=1, `dir`=0 -> `Case` 0->1 at edge 4, then 2,3,0 at edges 8,12,16; `tick`=1 one cycle after each.
- `run`=1, `dir`=1 from reset -> `Case` sequence 3,2,1,0 at edges 4,8,12,16.
- DEBOUNCE_CYCLES=3, `run`=0: `step_btn` pulses of 1-2 cycles -> no change. Clean press held 10 cycles -> `Case` 0->1 on edge 6, single `tick`. Release 5 cycles, re-press -> `Case`=2.
- `run`=1 with button press -> ignored. `run` dropped at prescaler=2 then raised -> next change exactly 4 edges after `run`=1 sampled.
- `Case`=2 mid-count, assert `reset` between clock edges -> `Case`=0 and `tick`=0 immediately; first change at edge 4 after release.
- With CASE_SEQUENCER_PINGPONG_EN, `run`=1, `dir`=1 -> `Case` sequence 0,1,2,3,2,1,0,1 (`dir` ignored).

Source files
------------

// File: rtl/case_sequencer_if.sv
// case_sequencer_if
//   Bundles the control inputs and select outputs of case_sequencer so the
//   sequencer and whoever drives it share one port.
//   Signals:
//     run       1 = auto-advance on the prescaler, 0 = manual button stepping
//     dir       0 = count up, 1 = count down
//     step_btn  raw asynchronous push button, active-high
//     Case[1:0] current select value for the LED lighter
//     tick      one-cycle strobe in the first cycle Case holds a new value
//   Modports:
//     master : stimulus side (drives run/dir/step_btn, observes Case/tick)
//     slave  : case_sequencer side
interface case_sequencer_if;
  logic       run;
  logic       dir;
  logic       step_btn;
  logic [1:0] Case;
  logic       tick;

  modport master (output run, dir, step_btn, input Case, tick);
  modport slave  (input run, dir, step_btn, output Case, tick);
endinterface

// File: rtl/case_sequencer.sv
// case_sequencer
//   Generates the 2-bit Case select for the one-hot LED lighter.
//   - run=1 : Case steps once every TICK_DIV clocks (free-running prescaler).
//   - run=0 : Case steps once per debounced rising edge of step_btn.
//   Each change of Case is marked by a one-cycle tick in the cycle that the
//   new value is first visible.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    case_sequencer_if.slave (run, dir, step_btn in; Case, tick out)
//
//   Parameters:
//     TICK_DIV         clocks per auto advance (>= 2)
//     DEBOUNCE_CYCLES  consecutive stable samples to accept a button change (>= 1)
//
//   Build option:
//     CASE_SEQUENCER_PINGPONG_EN - when defined, dir is ignored and Case
//     bounces 0,1,2,3,2,1,0,... using an internal direction flag. When not
//     defined, dir selects up/down with mod-4 wrap.
module case_sequencer #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  case_sequencer_if.slave    bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  // The WAIT states hold the number of stable samples seen so far; the
  // sample that arrives while count == DEBOUNCE_CYCLES-1 is the final one.
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DB_ONE   = CW'(1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer for the raw button
  // ---------------------------------------------------------------------
  logic [1:0] sync_ff;
  logic       sync_btn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= 2'b00;
    else       sync_ff <= {sync_ff[0], bus.step_btn};
  end

  assign sync_btn = sync_ff[1];

  // ---------------------------------------------------------------------
  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples of the new level; any bounce back restarts.
  // ---------------------------------------------------------------------
  logic [1:0]    db_state;
  logic [CW-1:0] db_cnt;
  logic          db_level;
  logic          db_level_d;
  logic          step_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_state <= IDLE_LOW;
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else begin
      case (db_state)
        IDLE_LOW: begin
          if (sync_btn) begin
            db_state <= WAIT_HIGH;
            db_cnt   <= DB_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!sync_btn) begin
            db_state <= IDLE_LOW;
            db_cnt   <= '0;
          end else if (db_cnt >= DB_LAST) begin
            db_state <= IDLE_HIGH;
            db_cnt   <= '0;
            db_level <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!sync_btn) begin
            db_state <= WAIT_LOW;
            db_cnt   <= DB_ONE;
          end
        end
        WAIT_LOW: begin
          if (sync_btn) begin
            db_state <= IDLE_HIGH;
            db_cnt   <= '0;
          end else if (db_cnt >= DB_LAST) begin
            db_state <= IDLE_LOW;
            db_cnt   <= '0;
            db_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          db_state <= IDLE_LOW;
          db_cnt   <= '0;
          db_level <= 1'b0;
        end
      endcase
    end
  end

  // Rising edge of the debounced level: one request per press, however long
  // the button is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) db_level_d <= 1'b0;
    else       db_level_d <= db_level;
  end

  assign step_req = db_level & ~db_level_d;

  // ---------------------------------------------------------------------
  // Prescaler: cleared while run=0, so the first auto advance after run
  // rises is a full TICK_DIV period away.
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          adv_auto;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  presc <= '0;
    else if (!bus.run)          presc <= '0;
    else if (presc == PRE_LAST) presc <= '0;
    else                        presc <= presc + 1'b1;
  end

  assign adv_auto = (presc == PRE_LAST);

  // run gates both sources, so run falling in the terminal cycle cancels
  // that advance and button requests are dropped in auto mode.
  logic adv;
  assign adv = (bus.run & adv_auto) | (~bus.run & step_req);

  // ---------------------------------------------------------------------
  // Next Case value
  // ---------------------------------------------------------------------
  logic [1:0] case_q;
  logic [1:0] case_nxt;
  logic       tick_q;

`ifdef CASE_SEQUENCER_PINGPONG_EN
  // Direction flag: 1 = up. It flips on the advance that would otherwise
  // wrap, and the step uses the flipped direction so the ends are visited
  // once (..2,3,2.. and ..1,0,1..).
  logic up_dir;
  logic up_nxt;

  always_comb begin
    up_nxt = up_dir;
    if (up_dir && (case_q == 2'd3))       up_nxt = 1'b0;
    else if (!up_dir && (case_q == 2'd0)) up_nxt = 1'b1;
    case_nxt = up_nxt ? (case_q + 2'd1) : (case_q - 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    up_dir <= 1'b1;
    else if (adv) up_dir <= up_nxt;
  end
`else
  // dir only matters in the advance cycle; 2-bit arithmetic wraps 3->0 / 0->3.
  always_comb begin
    case_nxt = bus.dir ? (case_q - 2'd1) : (case_q + 2'd1);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      case_q <= 2'b00;
      tick_q <= 1'b0;
    end else begin
      tick_q <= adv;
      if (adv) case_q <= case_nxt;
    end
  end

  assign bus.Case = case_q;
  assign bus.tick = tick_q;

endmodule
